// File: rtl/ptx_pkg.sv
// Shared state encoding and width helpers for the PTX call sequencer.
package ptx_pkg;

  localparam int MAX_CH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    CALL  = 2'd2
  } ptx_state_e;

  // Index width that never collapses to zero bits for single-entry ranges.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ptx_rr_arb.sv
// Combinational round-robin picker: first set request at or above ptr_i, wrapping.
// Zero latency; no flow control of its own.
module ptx_rr_arb import ptx_pkg::*; #(
  parameter  int NUM_CH = 4,
  localparam int CH_W   = idx_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [CH_W-1:0]   ptr_i,
  output logic              vld_o,
  output logic [CH_W-1:0]   idx_o
);

  logic [CH_W-1:0] cand;

  always_comb begin
    vld_o = 1'b0;
    idx_o = '0;
    cand  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = CH_W'((int'(ptr_i) + k) % NUM_CH);
      if (!vld_o && req_i[cand]) begin
        vld_o = 1'b1;
        idx_o = cand;
      end
    end
  end

endmodule

// File: rtl/ptx_call_sequencer.sv
// Queues per-channel export calls, grants round-robin, delays, then holds call_ev until xpt_rtn.
// Grant one cycle after a request lands; call_ev follows the CALL state by one cycle.
module ptx_call_sequencer import ptx_pkg::*; #(
  parameter  int NUM_CH = 4,
  parameter  int DLY_W  = 2,
  parameter  int DEPTH  = 4,
  localparam int CH_W   = idx_w(NUM_CH),
  localparam int CNT_W  = idx_w(DEPTH + 1)
) (
  input  logic              uClk,
  input  logic              uRst,
  input  logic [NUM_CH-1:0] call_req,
  input  logic              call_en,
  input  logic [DLY_W-1:0]  dly,
  input  logic              xpt_rtn,
  input  logic              ovf_clr,
  output logic              call_ev,
  output logic [CH_W-1:0]   call_ch,
  output logic              has_ptx,
  output logic [NUM_CH-1:0] pend_ovf
);

  ptx_state_e        state_q;
  logic [DLY_W-1:0]  timer_q;
  logic [CH_W-1:0]   call_ch_q;
  logic [CH_W-1:0]   rr_ptr_q;
  logic              call_ev_q;
  logic [NUM_CH-1:0] nz;
  logic              arb_vld;
  logic [CH_W-1:0]   arb_idx;
  logic              grant;

  ptx_rr_arb #(.NUM_CH(NUM_CH)) u_arb (
    .req_i (nz),
    .ptr_i (rr_ptr_q),
    .vld_o (arb_vld),
    .idx_o (arb_idx)
  );

  assign grant = (state_q == IDLE) && call_en && arb_vld;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             ovf_q;
    logic             dec;
    logic             full;
    logic             inc;

    assign dec   = grant && (arb_idx == CH_W'(i));
    assign full  = (cnt_q == CNT_W'(DEPTH));
    // A grant in the same cycle frees a slot, so a request at DEPTH is still accepted.
    assign inc   = call_req[i] && (!full || dec);
    assign cnt_d = cnt_q + CNT_W'(inc) - CNT_W'(dec);

    always_ff @(posedge uClk or posedge uRst) begin
      if (uRst) begin
        cnt_q <= '0;
        ovf_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        if (call_req[i] && full && !dec) begin
          ovf_q <= 1'b1;
        end else if (ovf_clr) begin
          ovf_q <= 1'b0;
        end
      end
    end

    assign nz[i]       = (cnt_q != '0);
    assign pend_ovf[i] = ovf_q;
  end

  always_ff @(posedge uClk or posedge uRst) begin
    if (uRst) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      call_ch_q <= '0;
      rr_ptr_q  <= '0;
      call_ev_q <= 1'b0;
    end else begin
      call_ev_q <= (state_q == CALL);
      case (state_q)
        IDLE: begin
          if (grant) begin
            call_ch_q <= arb_idx;
            timer_q   <= dly;
            state_q   <= (dly == '0) ? CALL : DELAY;
          end
        end
        DELAY: begin
          timer_q <= timer_q - DLY_W'(1);
          if (timer_q == DLY_W'(1)) begin
            state_q <= CALL;
          end
        end
        CALL: begin
          if (xpt_rtn) begin
            state_q  <= IDLE;
            rr_ptr_q <= (call_ch_q == CH_W'(NUM_CH - 1)) ? '0 : call_ch_q + CH_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign call_ev = call_ev_q;
  assign call_ch = call_ch_q;
  assign has_ptx = (state_q != IDLE) || (|nz);

endmodule

// File: doc/ptx_call_sequencer.md
Name: ptx_call_sequencer

Overview:
- Parametrised successor to the single-channel PTX transaction-top stub.
- Accepts export-call requests from NUM_CH channels and queues them per channel with saturating pending counters.
- Arbitrates round-robin, applies a programmable pre-call delay, then issues one call event at a time and holds it until the host return handshake arrives.
- Sits between DUT-side transactor channels and the emulator call/return interface. Always-on domain, clocked by uClk.

Parameters:
- NUM_CH, 4, number of request channels (1..16).
- DLY_W, 2, width of the pre-call delay value.
- DEPTH, 4, maximum pending calls per channel (counter saturates here).
- CH_W, $clog2(NUM_CH) (min 1), width of the channel index (derived).
- CNT_W, $clog2(DEPTH+1), width of the pending counter (derived).

Ports:
- uClk  in  1  sole clock.
- uRst  in  1  asynchronous active-high reset.
- call_req  in  NUM_CH  per-channel single-cycle request pulse; one call per asserted bit per cycle.
- call_en  in  1  global enable (callEvOn); 0 blocks new grants, keeps pending calls.
- dly  in  DLY_W  pre-call delay in cycles, sampled on grant.
- xpt_rtn  in  1  return handshake from host; completes the outstanding call.
- ovf_clr  in  1  clears all sticky overflow flags.
- call_ev  out  1  call event, level-high while a call is outstanding.
- call_ch  out  CH_W  channel index of the outstanding or delaying call.
- has_ptx  out  1  high if any counter is nonzero or the FSM is not IDLE.
- pend_ovf  out  NUM_CH  sticky: request dropped because the counter was at DEPTH.

Behaviour:
- Reset (async assert; deassertion is synchronous to uClk, handled by the top-level synchroniser): every output goes to 0. All counters, the delay timer and the round-robin pointer are 0. FSM goes to IDLE. Reset in DELAY or CALL aborts the call with no return expected.
- Pending counter, per channel, per cycle:
  - +1 if call_req[i] and count < DEPTH.
  - −1 if that channel is granted this cycle.
  - Both at once: count unchanged.
  - Request at DEPTH with no grant on that channel: request dropped, pend_ovf[i] set. It stays set until ovf_clr or reset.
  - ovf_clr and a new overflow in the same cycle: the flag stays set.
- Arbitration: in IDLE with call_en=1 and any count nonzero, pick the first nonzero channel searching from rr_ptr upward, wrapping modulo NUM_CH.
  - Grant decrements that counter, registers call_ch and loads the timer with dly.
  - rr_ptr becomes (granted+1) mod NUM_CH when the call completes.
- FSM states IDLE, DELAY, CALL:
  - IDLE→DELAY on grant if dly≠0.
  - IDLE→CALL on grant if dly=0.
  - DELAY: timer decrements each cycle; at timer==1 go to CALL. DELAY lasts exactly dly cycles.
  - CALL: call_ev=1. Go to IDLE on the cycle xpt_rtn is sampled high; call_ev drops the cycle after that.
  - xpt_rtn outside CALL is ignored.
  - call_en going low during DELAY or CALL does not abort the call.
- Latency: a req pulse at edge t gives count=1 after t. Grant at t+1; with dly=0, call_ev=1 from t+2.
  - Back-to-back: xpt_rtn at edge u gives IDLE at u. The next grant comes at u+1 and call_ev rises at u+2, a minimum 1-cycle gap with call_ev low.
- call_ch is stable from grant until leaving CALL, and holds its last value in IDLE.
- has_ptx: combinational OR of (state≠IDLE) and all counters nonzero.
- Widths: the timer is DLY_W bits. Counter arithmetic must never wrap; saturation is enforced before increment.

Decomposition:
- Package ptx_pkg holds:
  - the state enum (IDLE=2'd0, DELAY=2'd1, CALL=2'd2);
  - the CH_W/CNT_W derivation function;
  - a localparam MAX_CH=16.
- Sub-module ptx_rr_arb: a combinational round-robin priority picker. Inputs are the request vector and rr_ptr; outputs are a grant-valid flag and the index. Parametrised on NUM_CH.

Test Plan:
- Reset, then one pulse on call_req[2] with dly=0 → call_ev rises 2 cycles later with call_ch=2 and stays high 10 cycles until xpt_rtn; has_ptx drops the cycle after return.
- dly=3, request ch0 → exactly 3 DELAY cycles; call_ev rises on the 4th cycle after grant; call_ch=0 throughout.
- All 4 channels pulse together, xpt_rtn returned 1 cycle after each call_ev → grant order 0,1,2,3; with a second simultaneous burst the order is again 0,1,2,3, and rr_ptr=0 after the 8th call.
- 6 pulses on ch1 while call_en=0 → count saturates at 4 and pend_ovf[1]=1. Setting call_en=1 gives exactly 4 calls on ch1. ovf_clr clears the flag.
- Request on ch3 in the same cycle as its grant at count=2 → count stays 2; no overflow.
- uRst asserted mid-CALL → call_ev, has_ptx and pend_ovf all 0 immediately. A late xpt_rtn after reset is ignored and no call is issued.
